// File: rtl/trivium_top.sv
// rtl/trivium_top.sv - UART-attached Trivium stream cipher
//
// trivium_core: 288-bit Trivium state, one keystream step per cycle when
// step is high.
//   clk, rst_n    clock, async active-low reset (loads KEY/IV)
//   step          advance the state one step this cycle
//   z             keystream bit of the current state
//
// trivium_top: receives 8N1 bytes, XORs each with the next 8 keystream bits,
// and sends the result as 8N1. Encrypt and decrypt are the same operation.
//   clk           system clock
//   rst_n         async active-low reset
//   ena           global enable, 0 freezes every register
//   serial_in     bit 0 is the UART RX line, bits 7:1 ignored
//   serial_out    bit 0 is the UART TX line, bits 7:1 tied low

module trivium_core #(
  parameter logic [79:0] KEY = 80'h0123456789ABCDEF0123,
  parameter logic [79:0] IV  = 80'hFEDCBA9876543210FEDC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic z
);

  // s[i-1] holds Trivium state bit s_i.
  logic [287:0] s;
  logic         t1, t2, t3;
  logic         t1n, t2n, t3n;

  always_comb begin
    t1  = s[65] ^ s[92];
    t2  = s[161] ^ s[176];
    t3  = s[242] ^ s[287];
    t1n = t1 ^ (s[90] & s[91]) ^ s[170];
    t2n = t2 ^ (s[174] & s[175]) ^ s[263];
    t3n = t3 ^ (s[285] & s[286]) ^ s[68];
  end

  assign z = t1 ^ t2 ^ t3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= {3'b111, 112'b0, IV, 13'b0, KEY};
    end else if (step) begin
      // Each register shifts toward higher index; feedback enters at its head.
      s <= {s[286:177], t2n, s[175:93], t1n, s[91:0], t3n};
    end
  end

endmodule

module trivium_top #(
  parameter int          CLK_FREQ     = 100_000_000,
  parameter int          BAUD         = 9600,
  parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter logic [79:0] KEY          = 80'h0123456789ABCDEF0123,
  parameter logic [79:0] IV           = 80'hFEDCBA9876543210FEDC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] serial_in,
  output logic [7:0] serial_out
);

  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [10:0]    INIT_LAST = 11'd1151;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic unused_in;
  assign unused_in = ^serial_in[7:1];

  // RX
  rx_state_t     rx_state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;

  // Init / cipher / pending / TX
  logic [10:0]   init_cnt;
  logic          init_done;
  logic          rx_full;
  logic [7:0]    rx_hold;
  logic          ciph_busy;
  logic [2:0]    ciph_cnt;
  logic [7:0]    ciph_data;
  logic          pend_full;
  logic [7:0]    pend_data;
  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          tx_line;

  logic          z, step;
  logic          ciph_start, ciph_done;
  logic [7:0]    ciph_res;
  logic          tx_end, tx_free, load_en;
  logic [7:0]    load_data;

  trivium_core #(.KEY(KEY), .IV(IV)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .z     (z)
  );

  always_comb begin
    step       = ena && (!init_done || ciph_busy);
    ciph_start = init_done && rx_full && !ciph_busy;
    ciph_res   = ciph_data ^ ({7'b0, z} << ciph_cnt);
    ciph_done  = ciph_busy && (ciph_cnt == 3'd7);
    tx_end     = tx_busy && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);
    // TX can take a new byte when idle or in the last cycle of a stop bit,
    // which is what makes back-to-back frames gapless.
    tx_free    = !tx_busy || tx_end;
    load_en    = tx_free && (pend_full || ciph_done);
    load_data  = pend_full ? pend_data : ciph_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else if (ena) begin
      rx_meta  <= serial_in[0];
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            // A low stop bit is a framing error: drop the byte silently.
            rx_valid <= rx_sync;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
      rx_full   <= 1'b0;
      rx_hold   <= '0;
      ciph_busy <= 1'b0;
      ciph_cnt  <= '0;
      ciph_data <= '0;
      pend_full <= 1'b0;
      pend_data <= '0;
      tx_busy   <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_line   <= 1'b1;
    end else if (ena) begin
      if (!init_done) begin
        if (init_cnt == INIT_LAST) init_done <= 1'b1;
        else                       init_cnt  <= init_cnt + 1'b1;
      end

      // A received byte waits here until init is over and the cipher is free.
      if (ciph_start) rx_full <= 1'b0;
      if (rx_valid) begin
        rx_full <= 1'b1;
        rx_hold <= rx_shift;
      end

      if (ciph_start) begin
        ciph_busy <= 1'b1;
        ciph_cnt  <= '0;
        ciph_data <= rx_hold;
      end else if (ciph_busy) begin
        ciph_data <= ciph_res;
        ciph_cnt  <= ciph_cnt + 1'b1;
        if (ciph_done) ciph_busy <= 1'b0;
      end

      // Pending buffer: refilled from the cipher when it feeds TX, filled when
      // TX is busy, and a third byte is dropped (keystream already consumed).
      if (load_en && pend_full) begin
        pend_full <= ciph_done;
        pend_data <= ciph_res;
      end else if (ciph_done && !load_en && !pend_full) begin
        pend_full <= 1'b1;
        pend_data <= ciph_res;
      end

      if (load_en) begin
        tx_busy  <= 1'b1;
        tx_line  <= 1'b0;
        tx_shift <= {1'b1, load_data};
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end else if (tx_end) begin
        tx_busy <= 1'b0;
        tx_line <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_line  <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bit   <= tx_bit + 1'b1;
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  assign serial_out = {7'b0, tx_line};

endmodule

// File: tb/tb_trivium_top.sv
// tb/tb_trivium_top.sv - self-checking bench for trivium_top

module tb_trivium_top;

  localparam int          CPB = 20;
  localparam logic [79:0] KEY = 80'h0123456789ABCDEF0123;
  localparam logic [79:0] IV  = 80'hFEDCBA9876543210FEDC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] serial_in = 8'hFF;
  logic [7:0] serial_out;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_rel = 0;

  bit ms [1:288];

  trivium_top #(
    .CLK_FREQ     (200),
    .BAUD         (10),
    .CLKS_PER_BIT (CPB),
    .KEY          (KEY),
    .IV           (IV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .serial_in  (serial_in),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference Trivium, written directly on the s1..s288 numbering.
  task automatic model_step(output bit zo);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    zo = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
    ms[178] = t2;
    for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
    ms[94] = t1;
    for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
    ms[1] = t3;
  endtask

  task automatic model_reset();
    logic [79:0] k, v;
    bit zd;
    k = KEY;
    v = IV;
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      ms[i]      = k[i-1];
      ms[93 + i] = v[i-1];
    end
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
    repeat (1152) model_step(zd);
  endtask

  task automatic model_byte(output logic [7:0] kb);
    bit zb;
    for (int i = 0; i < 8; i++) begin
      model_step(zb);
      kb[i] = zb;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_out", serial_out, 8'h01);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t_rel = cyc;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    serial_in[7:1] = 7'($urandom);
    serial_in[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in[0] = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in[0] = stop;
    repeat (CPB) @(negedge clk);
    serial_in[0] = 1'b1;
  endtask

  task automatic wait_low(input int tmo, output bit seen);
    int w;
    w = 0;
    while (serial_out[0] !== 1'b0 && w < tmo) begin
      @(negedge clk);
      w++;
    end
    seen = (serial_out[0] === 1'b0);
  endtask

  task automatic recv_frame(input int tmo, output logic [7:0] d, output bit ok, output int ts);
    bit seen;
    d = '0;
    ok = 1'b0;
    ts = 0;
    wait_low(tmo, seen);
    if (!seen) return;
    ts = cyc;
    repeat (CPB / 2) @(negedge clk);
    if (serial_out[0] !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      d[i] = serial_out[0];
    end
    repeat (CPB) @(negedge clk);
    ok = (serial_out[0] === 1'b1);
  endtask

  task automatic watch_idle(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (serial_out !== 8'h01) bad++;
    end
  endtask

  task automatic run_burst(input logic [7:0] din[$], input string tag);
    logic [7:0] got[$];
    int         ts[$];
    int         t0, t, lat;
    logic [7:0] d, kexp;
    bit         ok;
    t0 = 0;
    fork
      begin
        t0 = cyc;
        foreach (din[i]) send_byte(din[i], 1'b1);
      end
      begin
        for (int i = 0; i < din.size(); i++) begin
          recv_frame(15 * CPB, d, ok, t);
          if (!ok) break;
          got.push_back(d);
          ts.push_back(t);
        end
      end
    join
    check({tag, "_count"}, got.size(), din.size());
    if (got.size() > 0) begin
      lat = ts[0] - t0;
      check({tag, "_latency_ok"}, (lat >= 9 * CPB + CPB / 2) && (lat <= 9 * CPB + CPB / 2 + 20), 1);
    end
    for (int i = 0; i < din.size(); i++) begin
      model_byte(kexp);
      if (i < got.size()) begin
        check($sformatf("%s_byte%0d", tag, i), got[i], din[i] ^ kexp);
        if (i > 0) check($sformatf("%s_gap%0d", tag, i), ts[i] - ts[i-1], 10 * CPB);
      end
    end
  endtask

  initial begin
    logic [7:0] d, kexp, lvl;
    logic [7:0] list[$];
    bit         ok, seen;
    int         t, bad;

    // Reset and an idle line: no start bit must appear.
    do_reset();
    watch_idle(2 * CPB, bad);
    check("idle_ff", bad, 0);

    // A5 arrives during init and is held until init completes.
    fork
      send_byte(8'hA5, 1'b1);
      recv_frame(2000, d, ok, t);
    join
    model_byte(kexp);
    check("a5_frame_ok", ok, 1);
    check("a5_data", d, 8'hA5 ^ kexp);
    check("a5_after_init", (t - t_rel >= 1152) && (t - t_rel <= 1180), 1);

    // Ten back-to-back frames, keystream continuing from K1.
    list = '{8'hA5, 8'h3C, 8'h7F, 8'hC1, 8'h99, 8'h42, 8'hE7, 8'hB8, 8'h5D, 8'hF0};
    run_burst(list, "burst");

    // Random back-to-back bytes.
    list.delete();
    for (int i = 0; i < 6; i++) list.push_back(8'($urandom));
    run_burst(list, "rand");

    // Framing error is discarded and does not consume keystream.
    do_reset();
    watch_idle(1160, bad);
    check("init_quiet", bad, 0);
    send_byte(8'h55, 1'b0);
    watch_idle(3 * CPB, bad);
    check("ferr_quiet", bad, 0);
    fork
      send_byte(8'h3C, 1'b1);
      recv_frame(15 * CPB, d, ok, t);
    join
    model_byte(kexp);
    check("ferr_next_ok", ok, 1);
    check("ferr_next_data", d, 8'h3C ^ kexp);
    watch_idle(12 * CPB, bad);
    check("ferr_single_frame", bad, 0);

    // Reset in the middle of a TX start bit.
    send_byte(8'h11, 1'b1);
    wait_low(4 * CPB, seen);
    check("rst_tx_seen", seen, 1);
    repeat (CPB / 2) @(negedge clk);
    check("rst_tx_low", serial_out, 8'h00);
    do_reset();
    watch_idle(1160, bad);
    check("rst_inflight_lost", bad, 0);
    fork
      send_byte(8'h7F, 1'b1);
      recv_frame(15 * CPB, d, ok, t);
    join
    model_byte(kexp);
    check("rst_7f_ok", ok, 1);
    check("rst_7f_data", d, 8'h7F ^ kexp);

    // ena=0 for two bit periods in the middle of a TX frame.
    send_byte(8'hC3, 1'b1);
    model_byte(kexp);
    wait_low(4 * CPB, seen);
    check("ena_tx_seen", seen, 1);
    repeat (CPB / 2) @(negedge clk);
    check("ena_start", serial_out, 8'h00);
    d = '0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      d[i] = serial_out[0];
      if (i == 2) begin
        ena = 1'b0;
        lvl = serial_out;
        repeat (2 * CPB) begin
          @(negedge clk);
          if (serial_out !== lvl) bad++;
        end
        ena = 1'b1;
      end
    end
    check("ena_freeze", bad, 0);
    repeat (CPB) @(negedge clk);
    check("ena_stop", serial_out, 8'h01);
    check("ena_data", d, 8'hC3 ^ kexp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trivium_top.md
# trivium_top

UART-attached Trivium stream cipher. The block receives 8N1 bytes on `serial_in[0]` and XORs each byte with the next 8 Trivium keystream bits. It transmits the result as 8N1 on `serial_out[0]`. It is the chip top for the encryption tile: a fixed key and IV are set by parameters, and the same operation both encrypts and decrypts.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 9600, UART bit rate for RX and TX.
- `CLKS_PER_BIT`, CLK_FREQ/BAUD (10416), clock cycles per UART bit.
- `KEY`, 80'h0123456789ABCDEF0123, Trivium key.
- `IV`, 80'hFEDCBA9876543210FEDC, Trivium IV.
- `clk`  in  1  system clock. The block uses one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  global enable; 0 freezes all registers.
- `serial_in`  in  8  bit 0 is the UART RX line (idle high); bits 7:1 are ignored.
- `serial_out`  out  8  bit 0 is the UART TX line (idle high); bits 7:1 are always 0.

## Operation
- Reset:
  - state s1..s80 = KEY[0..79]; s81..s93 = 0.
  - s94..s173 = IV[0..79]; s174..s285 = 0; s286..s288 = 1.
  - RX and TX are idle, the pending buffer is empty, and `serial_out` = 8'h01.
- Init phase:
  - After reset release, the core clocks 1152 times (4x288) with the output discarded; `init_done` is then set.
  - A byte received before `init_done` is held in the RX register until init completes.
- Trivium step:
  - t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
  - t1'=t1^(s91&s92)^s171, t2'=t2^(s175&s176)^s264, t3'=t3^(s286&s287)^s69.
  - Shift: s1..s93 <= {t3',s1..s92}, s94..s177 <= {t1',s94..s176}, s178..s288 <= {t2',s178..s287}.
  - Steps occur only during init or on a cipher request.
- RX:
  - 2-flop synchronizer on `serial_in[0]`.
  - A falling edge starts a frame. The start bit is re-checked at CLKS_PER_BIT/2 and the frame is aborted if the line is high.
  - 8 data bits are sampled LSB first at bit centers, followed by the stop bit.
  - Stop bit = 0 is a framing error: the byte is discarded and the keystream does not advance.
- Cipher:
  - A valid byte triggers 8 consecutive steps; the i-th z is XORed into data bit i.
  - The keystream is continuous across bytes and restarts only on reset.
- TX:
  - 8N1 output: start 0, data LSB first, stop 1, each bit lasting CLKS_PER_BIT cycles.
  - Ciphertext goes to TX if TX is idle, otherwise into a one-byte pending buffer.
  - If the pending buffer is already full, the new byte is dropped and the keystream has still advanced.
- `ena`=0: all registers, including the baud counters, hold and the outputs keep their values.

## Timing
- Init completes 1152 enabled cycles after reset release.
- Latency: the TX start bit begins no more than 12 cycles after the RX stop-bit center sample.
- Each TX frame is exactly 10*CLKS_PER_BIT cycles. Back-to-back TX frames have no idle gap when the pending buffer is full.
- RX is ready for a new start edge immediately after the stop-bit sample.
- Input at the nominal baud rate with continuous frames never overflows.
- `rst_n` asserted mid-operation: `serial_out` goes to 8'h01 asynchronously and all in-flight bytes are lost. After release, init reruns and the keystream restarts from the first byte.
- Reset values: `serial_out`=8'h01; all internal counters are 0.

## Test plan
- Reset, then hold `serial_in`=8'hFF for 2 bit periods -> `serial_out` stays 8'h01 with no start bit.
- Send 0xA5 at 9600 baud (104160 ns/bit) after init -> one 8N1 frame out whose data = 0xA5^K0, where K0 comes from a bit-exact Trivium model with the default KEY/IV.
- Send A5 3C 7F C1 99 42 E7 B8 5D F0 back-to-back -> 10 frames out, byte i = in_i^K_i, with none dropped and in order.
- Send a frame with stop bit 0, then 0x3C -> only one output frame, data = 0x3C^K0.
- Pulse `rst_n` low mid TX frame -> `serial_out` = 8'h01 immediately; the next byte 0x7F yields 0x7F^K0.
- Hold `ena`=0 for 2 bit periods mid-frame, then set it to 1 -> the line level freezes and the frame then completes with correct data and length.
